// File: rtl/fp24_mul_arbiter.sv
// fp24_mul_arbiter
// Round-robin arbiter that shares one fp24 multiplier among NUM_REQ requesters.
// Each granted operand pair goes straight to the multiplier. A tag pipe that is
// MUL_LAT deep follows it, so each product can be paired with its requester ID.
// Products land in a show-ahead result FIFO. Issue is credit-limited so that the
// FIFO can never overflow.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b         packed fp24 operands, requester i at [24*i +: 24]
//   mul_a/mul_b         operands to the shared multiplier (zero when idle)
//   mul_prod            multiplier result, valid MUL_LAT cycles after issue
//   resp_valid/ready    result FIFO head handshake
//   resp_prod/resp_id   head product and the requester that issued it
//   stat_issued/stall   issue and stall counters (only with FP24_MUL_ARB_STATS_EN)
//
// Optional feature macro: FP24_MUL_ARB_STATS_EN

module fp24_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*24-1:0]      req_a,
    input  logic [NUM_REQ*24-1:0]      req_b,
    output logic [23:0]                mul_a,
    output logic [23:0]                mul_b,
    input  logic [23:0]                mul_prod,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [23:0]                resp_prod,
    output logic [$clog2(NUM_REQ)-1:0] resp_id
`ifdef FP24_MUL_ARB_STATS_EN
    ,
    output logic [31:0]                stat_issued,
    output logic [31:0]                stat_stall
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [IDW:0] NREQ_W    = (IDW+1)'(NUM_REQ);
    localparam logic [CW:0]  DEPTH_OCC = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [IDW-1:0] tag_id_q [MUL_LAT];
    logic [IDW-1:0] tag_id_d [MUL_LAT];
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [23:0] fifo_prod_q [FIFO_DEPTH];
    logic [23:0] fifo_prod_d [FIFO_DEPTH];
    logic [IDW-1:0] fifo_id_q [FIFO_DEPTH];
    logic [IDW-1:0] fifo_id_d [FIFO_DEPTH];

    logic [CW:0]    occ;
    logic           credit_ok;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand_w;
    logic           issue;
    logic           complete;
    logic           push;
    logic           pop;

    // A pop in the current cycle is deliberately not credited, so the credit
    // check depends only on registered state.
    assign occ       = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign credit_ok = occ < DEPTH_OCC;

    // Cyclic priority scan that starts just after the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_w    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_w = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand_w >= NREQ_W) begin
                cand_w = cand_w - NREQ_W;
            end
            if (!gnt_found && req_valid[cand_w[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_w[IDW-1:0];
            end
        end
    end

    assign issue     = credit_ok && gnt_found;
    assign req_ready = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign mul_a     = issue ? req_a[24*gnt_idx +: 24] : '0;
    assign mul_b     = issue ? req_b[24*gnt_idx +: 24] : '0;

    assign complete   = tag_vld_q[MUL_LAT-1];
    assign push       = complete;
    assign resp_valid = (fifo_cnt_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_prod  = fifo_prod_q[rd_ptr_q];
    assign resp_id    = fifo_id_q[rd_ptr_q];

    always_comb begin
        rr_ptr_d     = issue ? gnt_idx : rr_ptr_q;
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = gnt_idx;
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
        inflight_d = inflight_q + CW'(issue) - CW'(complete);
    end

    always_comb begin
        fifo_prod_d = fifo_prod_q;
        fifo_id_d   = fifo_id_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_prod_d[wr_ptr_q] = mul_prod;
            fifo_id_d[wr_ptr_q]   = tag_id_q[MUL_LAT-1];
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= IDW'(NUM_REQ - 1);
            tag_vld_q  <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                fifo_prod_q[e] <= '0;
                fifo_id_q[e]   <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_prod_q <= fifo_prod_d;
            fifo_id_q   <= fifo_id_d;
        end
    end

    // The credit check should make a push into a full FIFO impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (fifo_cnt_q == DEPTH_CNT)));

`ifdef FP24_MUL_ARB_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic        stall;

    // Any requester waiting while nothing is accepted.
    assign stall = (|req_valid) && !issue;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (issue && (stat_issued_q != '1)) begin
            stat_issued_d = stat_issued_q + 32'd1;
        end
        if (stall && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_fp24_mul_arbiter.sv
module tb_fp24_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [95:0] req_a;
    logic [95:0] req_b;
    logic [23:0] mul_a;
    logic [23:0] mul_b;
    logic [23:0] mul_prod = 24'h0;
    logic        resp_valid;
    logic        resp_ready;
    logic [23:0] resp_prod;
    logic [1:0]  resp_id;
`ifdef FP24_MUL_ARB_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp24_mul_arbiter #(.NUM_REQ(4), .MUL_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_prod   (mul_prod),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_prod  (resp_prod),
        .resp_id    (resp_id)
`ifdef FP24_MUL_ARB_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stall (stat_stall)
`endif
    );

    // fp24 = 1 sign, 7 exponent (bias 63), 16 mantissa; truncating multiplier.
    function automatic logic [23:0] fp24_mul(input logic [23:0] a, input logic [23:0] b);
        logic [16:0] ma;
        logic [16:0] mb;
        logic [33:0] p;
        logic [7:0]  e;
        logic        s;
        s = a[23] ^ b[23];
        if (a[22:16] == 7'd0 || b[22:16] == 7'd0) return {s, 23'd0};
        ma = {1'b1, a[15:0]};
        mb = {1'b1, b[15:0]};
        p  = 34'(ma) * 34'(mb);
        e  = 8'(a[22:16]) + 8'(b[22:16]) - 8'd63;
        if (p[33]) return {s, 7'(e + 8'd1), p[32:17]};
        return {s, e[6:0], p[31:16]};
    endfunction

    // Single-cycle multiplier model.
    always @(posedge clk) mul_prod <= fp24_mul(mul_a, mul_b);

    // Hand-computed products for the fixed per-requester operands:
    // r0 2.0*2.0=4.0, r1 1.5*1.5=2.25, r2 1.5*2.0=3.0, r3 1.0*1.25=1.25
    logic [23:0] exp_prod [4] = '{24'h410000, 24'h402000, 24'h408000, 24'h3F4000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: issues push {id, expected product}; pops compare in order.
    logic [25:0] sb [$];
    logic [25:0] sb_head;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    sb_head = sb.pop_front();
                    chk("sb_resp_id", 32'(resp_id), 32'(sb_head[25:24]));
                    chk("sb_resp_prod", 32'(resp_prod), 32'(sb_head[23:0]));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) sb.push_back({2'(i), exp_prod[i]});
            end
        end
    end

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic       exp_rv;
    } vec_t;
    vec_t tab [12];

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 4'b0;
        resp_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc_end();
    endtask

    task automatic drain();
        req_valid  = 4'b0;
        resp_ready = 1'b1;
        repeat (8) cyc_end();
        @(negedge clk);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_resp_valid", 32'(resp_valid), 32'd0);
        cyc_end();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        tab[0]  = '{4'b1111, 4'b0001, 1'b0};
        tab[1]  = '{4'b1111, 4'b0010, 1'b0};
        tab[2]  = '{4'b1111, 4'b0100, 1'b1};
        tab[3]  = '{4'b1111, 4'b1000, 1'b1};
        tab[4]  = '{4'b1111, 4'b0001, 1'b1};
        tab[5]  = '{4'b1111, 4'b0010, 1'b1};
        tab[6]  = '{4'b1001, 4'b1000, 1'b1};
        tab[7]  = '{4'b1001, 4'b0001, 1'b1};
        tab[8]  = '{4'b0000, 4'b0000, 1'b1};
        tab[9]  = '{4'b0110, 4'b0010, 1'b1};
        tab[10] = '{4'b0001, 4'b0001, 1'b0};
        tab[11] = '{4'b1000, 4'b1000, 1'b1};

        req_a = {24'h3F0000, 24'h3F8000, 24'h3F8000, 24'h400000};
        req_b = {24'h3F4000, 24'h400000, 24'h3F8000, 24'h400000};
        rst_n      = 1'b0;
        req_valid  = 4'b0;
        resp_ready = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_prod", 32'(resp_prod), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc_end();

        // Single op from requester 2
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'b0100);
        chk("single_mul_a", 32'(mul_a), 32'h3F8000);
        chk("single_mul_b", 32'(mul_b), 32'h400000);
        cyc_end();
        req_valid = 4'b0;
        @(negedge clk);
        chk("single_rv_t1", 32'(resp_valid), 32'd0);
        chk("idle_mul_a", 32'(mul_a), 32'd0);
        cyc_end();
        resp_ready = 1'b1;
        @(negedge clk);
        chk("single_rv_t2", 32'(resp_valid), 32'd1);
        chk("single_prod", 32'(resp_prod), 32'h408000);
        chk("single_id", 32'(resp_id), 32'd2);
        cyc_end();
        resp_ready = 1'b0;
        @(negedge clk);
        chk("single_rv_t3", 32'(resp_valid), 32'd0);
        cyc_end();

        // Round-robin and steady push/pop stream
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_valid = tab[i].valid;
            @(negedge clk);
            chk($sformatf("rr_ready[%0d]", i), 32'(req_ready), 32'(tab[i].exp_ready));
            chk($sformatf("rr_resp_valid[%0d]", i), 32'(resp_valid), 32'(tab[i].exp_rv));
            cyc_end();
        end
        drain();

        // Backpressure: credits exhaust after FIFO_DEPTH issues
        do_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("bp_ready[%0d]", c), 32'(req_ready),
                (c < 4) ? (32'd1 << c) : 32'd0);
            cyc_end();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_not_credited", 32'(req_ready), 32'd0);
        chk("bp_head_id", 32'(resp_id), 32'd0);
        cyc_end();
        resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_one_more", 32'(req_ready), 32'b0001);
        cyc_end();
        @(negedge clk);
        chk("bp_full_again", 32'(req_ready), 32'd0);
        cyc_end();
        drain();

        // Reset while 3 results are queued and 1 is in flight
        do_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        repeat (4) cyc_end();
        req_valid = 4'b0;
        chk("pre_rst_valid", 32'(resp_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_prod", 32'(resp_prod), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n      = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_first_grant", 32'(req_ready), 32'b0001);
        chk("midrst_rv0", 32'(resp_valid), 32'd0);
        cyc_end();
        req_valid = 4'b0;
        @(negedge clk);
        chk("midrst_no_stale", 32'(resp_valid), 32'd0);
        cyc_end();
        @(negedge clk);
        chk("midrst_rv_fresh", 32'(resp_valid), 32'd1);
        chk("midrst_fresh_id", 32'(resp_id), 32'd0);
        chk("midrst_fresh_prod", 32'(resp_prod), 32'h410000);
        cyc_end();
        drain();

`ifdef FP24_MUL_ARB_STATS_EN
        // 10 issues and 5 credit-starved cycles
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        repeat (6) cyc_end();
        req_valid = 4'b0;
        repeat (4) cyc_end();
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        repeat (9) cyc_end();
        req_valid = 4'b0;
        @(negedge clk);
        chk("stat_issued", stat_issued, 32'd10);
        chk("stat_stall", stat_stall, 32'd5);
        cyc_end();
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp24_mul_arbiter.md
Name: fp24_mul_arbiter

Overview:
Round-robin arbiter that shares one fp24 multiplier among NUM_REQ requesters. Each requester presents an operand pair through a valid/ready handshake. The arbiter drives the multiplier's operand inputs and tracks in-flight tags through the multiplier's fixed pipeline latency. Results land in a credit-protected output FIFO, and each result is returned with its requester ID. It sits between the shading/intersection units and the single shared fp24 multiply datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
MUL_LAT, 1, multiplier latency in cycles, from operands presented to mul_prod valid (>=1).
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*24  packed fp24 operand A; requester i at [24*i+:24]
req_b  in  NUM_REQ*24  packed fp24 operand B, same packing
mul_a  out  24  operand A to the shared multiplier
mul_b  out  24  operand B to the shared multiplier
mul_prod  in  24  multiplier result, valid MUL_LAT cycles after issue
resp_valid  out  1  result available at FIFO head
resp_ready  in  1  consumer accepts head
resp_prod  out  24  fp24 product at FIFO head
resp_id  out  $clog2(NUM_REQ)  requester that issued the head result

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low. All state clears on assertion.
- Reset values: FIFO empty, resp_valid=0, resp_prod=0, resp_id=0, in-flight pipe cleared, rr pointer=NUM_REQ-1 (so requester 0 has first priority).
- Reset mid-operation: in-flight tags and FIFO contents are discarded. mul_prod is ignored until a fresh issue's tag matures.
- Credit: occ = fifo_count + inflight_count. Issue is allowed iff occ < FIFO_DEPTH. A same-cycle FIFO pop is not credited, which keeps the check conservative and registered-only.
- Arbitration (combinational):
  - grant = first i with req_valid[i], scanning cyclically from rr_ptr+1.
  - req_ready = onehot(grant) when issue is allowed, else 0.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
- Issue (a handshake req_valid[i]&&req_ready[i]):
  - mul_a/mul_b = req_a[i]/req_b[i] in the same cycle.
  - rr_ptr <= i.
  - A tag {1, i} enters stage 0 of the MUL_LAT-deep tag pipe.
  - With no issue, mul_a=mul_b=0 and a tag {0, x} enters the pipe.
- One issue at most per cycle; sustained throughput is 1 product/cycle while credits last.
- Completion: when the last tag stage is valid, {id, mul_prod} is written to the FIFO in that cycle, and inflight_count decrements.
- FIFO behaviour:
  - Show-ahead: resp_valid = !empty; resp_prod and resp_id come from the head.
  - Pop on resp_valid&&resp_ready.
  - Simultaneous push and pop are both performed and the count is unchanged.
  - Push into a full FIFO cannot occur because of the credit check; an assertion flags it.
- Pointers wrap modulo FIFO_DEPTH. rr_ptr wraps modulo NUM_REQ.
- Latency: issue at cycle t; product written at t+MUL_LAT; resp_valid high at t+MUL_LAT+1 (FIFO registered).
- Ordering: results leave in issue order.
- The arbiter performs no arithmetic on operands and never inspects fp24 fields.

Optional Feature:
FP24_MUL_ARB_STATS_EN:
- Defined: adds outputs stat_issued (32b, counts issues) and stat_stall (32b, counts cycles with any req_valid but zero req_ready). Both counters reset to 0, saturate at all-ones, and are read-only.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Single op: after reset, req_valid[2]=1, req_a=0x3F8000 (1.5), req_b=0x400000 (2.0), multiplier model MUL_LAT=1 -> req_ready=0b0100 in the same cycle; 2 cycles later resp_valid=1, resp_prod=0x408000 (3.0), resp_id=2.
- Round-robin fairness: all 4 requesters hold valid, resp_ready=1 -> grants follow 0,1,2,3,0,1,…, one per cycle, with no requester granted twice in any 4-cycle window.
- Backpressure: FIFO_DEPTH=4, resp_ready=0, all requesters valid -> exactly 4 issues, then req_ready=0 indefinitely; raising resp_ready for one cycle pops one entry and allows one further issue on the following cycle.
- Simultaneous push/pop: steady stream with resp_ready=1 -> FIFO count is constant at 1 and outputs arrive in issue order; 1.5*1.5 returns 0x402000.
- Reset mid-flight: drop rst_n while 3 results are queued and 1 is in flight -> resp_valid=0 immediately; after release, no stale result appears and the first grant goes to requester 0.
- Stats (macro defined): 10 issues plus 5 credit-starved cycles -> stat_issued=10, stat_stall=5.
